// File: rtl/riscv_wb_arbiter.sv
// Round-robin arbiter for the register-file write port, plus a busy scoreboard
// that stalls issue on RAW/WAW hazards against outstanding destination registers.
module riscv_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [5*NUM_REQ-1:0]    req_rd,
  input  logic [XLEN*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic                    issue_valid,
  input  logic                    issue_wb,
  input  logic [4:0]              issue_rs1,
  input  logic [4:0]              issue_rs2,
  input  logic [4:0]              issue_rd,
  output logic                    issue_stall,
  output logic                    reg_write_en,
  output logic [4:0]              rd,
  output logic [XLEN-1:0]         data_to_reg,
  output logic                    idle
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] NUM_REQ_C = CNT_W'(NUM_REQ);

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant;
  logic              fire;
  logic [4:0]        sel_rd;
  logic [XLEN-1:0]   sel_data;
  logic              reg_write_en_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   data_q;
  logic [31:0]       busy_q, busy_d;
  logic              accept;

  // Walk the requesters starting at ptr; the first valid one wins and the
  // pointer moves just past it so it becomes lowest priority next time.
  always_comb begin : arbitrate
    logic [CNT_W-1:0] pos;
    logic             found;
    // NOTE: every variable gets a default before any conditional write so no latch is inferred.
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, ptr_q} + CNT_W'(k);
      if (pos >= NUM_REQ_C) pos = pos - NUM_REQ_C;
      if (!found && req_valid[pos[PTR_W-1:0]]) begin
        found                = 1'b1;
        grant[pos[PTR_W-1:0]] = 1'b1;
        pos                  = pos + 1'b1;
        if (pos >= NUM_REQ_C) pos = '0;
        ptr_d = pos[PTR_W-1:0];
      end
    end
  end

  assign req_ready = rst ? grant : '0;
  assign fire      = |req_ready;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_rd   = req_rd[5*i +: 5];
        sel_data = req_data[XLEN*i +: XLEN];
      end
    end
  end

  assign issue_stall = rst & issue_valid &
                       (busy_q[issue_rs1] | busy_q[issue_rs2] | (issue_wb & busy_q[issue_rd]));
  assign accept      = issue_valid & ~issue_stall;

  // Clear for the write now in the regfile first, then set, so a same-cycle set wins.
  always_comb begin
    busy_d = busy_q;
    if (reg_write_en_q) busy_d[rd_q] = 1'b0;
    if (accept && issue_wb && (issue_rd != 5'd0)) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst) begin
      ptr_q          <= '0;
      reg_write_en_q <= 1'b0;
      rd_q           <= '0;
      data_q         <= '0;
      busy_q         <= '0;
    end else begin
      busy_q         <= busy_d;
      reg_write_en_q <= fire && (sel_rd != 5'd0);
      if (fire) begin
        ptr_q  <= ptr_d;
        rd_q   <= sel_rd;
        data_q <= sel_data;
      end
    end
  end

  assign reg_write_en = reg_write_en_q;
  assign rd           = rd_q;
  assign data_to_reg  = data_q;
  assign idle         = (busy_q == 32'd0) && !reg_write_en_q;

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Self-checking bench for riscv_wb_arbiter: directed scenarios plus a randomized
// run compared against a request-queue / busy-set reference model.
module tb_riscv_wb_arbiter;
  localparam int N = 3;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [5*N-1:0]  req_rd;
  logic [XLEN*N-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            issue_valid, issue_wb;
  logic [4:0]      issue_rs1, issue_rs2, issue_rd;
  logic            issue_stall;
  logic            reg_write_en;
  logic [4:0]      rd;
  logic [XLEN-1:0] data_to_reg;
  logic            idle;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] rf [32];

  riscv_wb_arbiter #(.NUM_REQ(N), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data), .req_ready(req_ready),
    .issue_valid(issue_valid), .issue_wb(issue_wb), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .issue_rd(issue_rd), .issue_stall(issue_stall),
    .reg_write_en(reg_write_en), .rd(rd), .data_to_reg(data_to_reg), .idle(idle)
  );

  always #5 clk = ~clk;

  // Regfile stand-in: writes land on the negedge.
  always @(negedge clk) if (reg_write_en) rf[rd] <= data_to_reg;

  task automatic clear_inputs();
    req_valid = '0; req_rd = '0; req_data = '0;
    issue_valid = 1'b0; issue_wb = 1'b0;
    issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    req_valid = '1; req_rd = {5'd3, 5'd2, 5'd1};
    issue_valid = 1'b1; issue_rs1 = 5'd1; issue_rs2 = 5'd2;
    repeat (2) @(negedge clk);
    #1;
    n_tests++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready: got %b want 000", req_ready); end
    n_tests++; if (reg_write_en !== 1'b0) begin n_fail++; $display("FAIL reset_wen: got %b want 0", reg_write_en); end
    n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b want 1", idle); end
    n_tests++; if (issue_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", issue_stall); end
    n_tests++; if (rd !== 5'd0 || data_to_reg !== 32'd0) begin n_fail++; $display("FAIL reset_regs: got rd=%0d data=%h want 0/0", rd, data_to_reg); end
    rst = 1'b1;
    clear_inputs();
  endtask

  task automatic test_single_write();
    do_reset();
    req_valid = 3'b001; req_rd[4:0] = 5'd5; req_data[31:0] = 32'hDEAD_BEEF;
    #1;
    n_tests++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL single_ready: got %b want 001", req_ready); end
    @(negedge clk); req_valid = '0; #1;
    n_tests++; if (reg_write_en !== 1'b1 || rd !== 5'd5 || data_to_reg !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL single_out: got wen=%b rd=%0d data=%h want 1/5/deadbeef", reg_write_en, rd, data_to_reg); end
    @(negedge clk); #1;
    n_tests++; if (reg_write_en !== 1'b0) begin n_fail++; $display("FAIL single_wen_drop: got %b want 0", reg_write_en); end
    n_tests++; if (rf[5] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_rf: got %h want deadbeef", rf[5]); end
  endtask

  task automatic test_round_robin();
    do_reset();
    req_valid = 3'b111; req_rd = {5'd3, 5'd2, 5'd1};
    req_data = {32'h2222, 32'h1111, 32'h0000};
    for (int g = 0; g < 6; g++) begin
      logic [N-1:0] exp_r;
      exp_r = '0; exp_r[g % N] = 1'b1;
      #1;
      n_tests++; if (req_ready !== exp_r) begin n_fail++; $display("FAIL rr_grant%0d: got %b want %b", g, req_ready, exp_r); end
      if (g > 0) begin
        n_tests++; if (reg_write_en !== 1'b1 || rd !== 5'(((g - 1) % N) + 1)) begin
          n_fail++; $display("FAIL rr_write%0d: got wen=%b rd=%0d want 1/%0d", g, reg_write_en, rd, ((g - 1) % N) + 1); end
      end
      @(negedge clk);
    end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_raw_stall();
    do_reset();
    issue_valid = 1'b1; issue_wb = 1'b1; issue_rd = 5'd7;
    #1;
    n_tests++; if (issue_stall !== 1'b0) begin n_fail++; $display("FAIL raw_first_issue: got %b want 0", issue_stall); end
    @(negedge clk);
    issue_wb = 1'b0; issue_rd = 5'd0; issue_rs1 = 5'd7;
    req_valid = 3'b010; req_rd[9:5] = 5'd7; req_data[63:32] = 32'h7777_0007;
    #1;
    n_tests++; if (issue_stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall_N: got %b want 1", issue_stall); end
    n_tests++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL raw_ready: got %b want 010", req_ready); end
    @(negedge clk); req_valid = '0; #1;
    n_tests++; if (issue_stall !== 1'b1 || reg_write_en !== 1'b1 || rd !== 5'd7) begin
      n_fail++; $display("FAIL raw_N1: got stall=%b wen=%b rd=%0d want 1/1/7", issue_stall, reg_write_en, rd); end
    @(negedge clk); #1;
    n_tests++; if (issue_stall !== 1'b0) begin n_fail++; $display("FAIL raw_N2: got %b want 0", issue_stall); end
    n_tests++; if (rf[7] !== 32'h7777_0007) begin n_fail++; $display("FAIL raw_rf: got %h want 77770007", rf[7]); end
    clear_inputs();
  endtask

  task automatic test_x0();
    do_reset();
    req_valid = 3'b100; req_rd[14:10] = 5'd0; req_data[95:64] = 32'd1;
    #1;
    n_tests++; if (req_ready !== 3'b100) begin n_fail++; $display("FAIL x0_ready: got %b want 100", req_ready); end
    @(negedge clk);
    req_valid = 3'b111; req_rd = {5'd0, 5'd0, 5'd0};
    #1;
    n_tests++; if (reg_write_en !== 1'b0) begin n_fail++; $display("FAIL x0_wen: got %b want 0", reg_write_en); end
    n_tests++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL x0_ptr: got %b want 001", req_ready); end
    @(negedge clk);
    req_valid = '0; issue_valid = 1'b1; issue_wb = 1'b1; issue_rd = 5'd0;
    @(negedge clk);
    issue_wb = 1'b0; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
    #1;
    n_tests++; if (issue_stall !== 1'b0 || idle !== 1'b1) begin
      n_fail++; $display("FAIL x0_busy: got stall=%b idle=%b want 0/1", issue_stall, idle); end
    clear_inputs();
  endtask

  task automatic test_collision();
    do_reset();
    req_valid = 3'b001; req_rd[4:0] = 5'd3; req_data[31:0] = 32'hAA;
    @(negedge clk);
    req_valid = '0;
    issue_valid = 1'b1; issue_wb = 1'b1; issue_rd = 5'd3;
    #1;
    n_tests++; if (reg_write_en !== 1'b1 || rd !== 5'd3 || issue_stall !== 1'b0) begin
      n_fail++; $display("FAIL coll_setup: got wen=%b rd=%0d stall=%b want 1/3/0", reg_write_en, rd, issue_stall); end
    @(negedge clk);
    issue_wb = 1'b0; issue_rd = 5'd0; issue_rs1 = 5'd3;
    #1;
    n_tests++; if (issue_stall !== 1'b1 || idle !== 1'b0) begin
      n_fail++; $display("FAIL coll_set_wins: got stall=%b idle=%b want 1/0", issue_stall, idle); end
    clear_inputs();
  endtask

  task automatic test_mid_reset();
    do_reset();
    req_valid = 3'b001; req_rd[4:0] = 5'd0;
    issue_valid = 1'b1; issue_wb = 1'b1; issue_rd = 5'd9;
    @(negedge clk);
    clear_inputs();
    req_valid = 3'b010; req_rd[9:5] = 5'd4;
    rst = 1'b0;
    #1;
    n_tests++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL mrst_ready: got %b want 000", req_ready); end
    @(negedge clk);
    rst = 1'b1;
    req_valid = 3'b111; req_rd = {5'd0, 5'd0, 5'd0};
    issue_valid = 1'b1; issue_rs1 = 5'd9;
    #1;
    n_tests++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL mrst_ptr: got %b want 001", req_ready); end
    n_tests++; if (issue_stall !== 1'b0 || idle !== 1'b1) begin
      n_fail++; $display("FAIL mrst_busy: got stall=%b idle=%b want 0/1", issue_stall, idle); end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_random();
    bit          m_busy [32];
    int          m_ptr;
    bit          m_wen;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    bit          pend  [N];
    logic [4:0]  prd   [N];
    logic [31:0] pdata [N];
    do_reset();
    m_ptr = 0; m_wen = 1'b0; m_rd = '0; m_data = '0;
    foreach (m_busy[r]) m_busy[r] = 1'b0;
    foreach (pend[i]) begin pend[i] = 1'b0; prd[i] = '0; pdata[i] = '0; end
    for (int t = 0; t < 400; t++) begin
      int g;
      bit any_busy, exp_stall, acc;
      logic [N-1:0] exp_r;
      any_busy = 1'b0;
      foreach (m_busy[r]) any_busy |= m_busy[r];
      #1;
      n_tests++; if (reg_write_en !== m_wen || rd !== m_rd || data_to_reg !== m_data) begin
        n_fail++; $display("FAIL rnd_out t=%0d: got wen=%b rd=%0d data=%h want %b/%0d/%h",
                           t, reg_write_en, rd, data_to_reg, m_wen, m_rd, m_data); end
      n_tests++; if (idle !== (!any_busy && !m_wen)) begin
        n_fail++; $display("FAIL rnd_idle t=%0d: got %b want %b", t, idle, !any_busy && !m_wen); end
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1; prd[i] = 5'($urandom_range(0, 7)); pdata[i] = $urandom;
        end
        req_valid[i] = pend[i];
        req_rd[5*i +: 5] = prd[i];
        req_data[XLEN*i +: XLEN] = pdata[i];
      end
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_wb    = ($urandom_range(0, 2) != 0);
      issue_rs1   = 5'($urandom_range(0, 7));
      issue_rs2   = 5'($urandom_range(0, 7));
      issue_rd    = 5'($urandom_range(0, 7));
      #1;
      g = -1;
      for (int k = 0; k < N; k++) if (g < 0 && pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      exp_r = '0;
      if (g >= 0) exp_r[g] = 1'b1;
      exp_stall = issue_valid && (m_busy[issue_rs1] || m_busy[issue_rs2] || (issue_wb && m_busy[issue_rd]));
      n_tests++; if (req_ready !== exp_r) begin n_fail++; $display("FAIL rnd_ready t=%0d: got %b want %b", t, req_ready, exp_r); end
      n_tests++; if (issue_stall !== exp_stall) begin n_fail++; $display("FAIL rnd_stall t=%0d: got %b want %b", t, issue_stall, exp_stall); end
      acc = issue_valid && !exp_stall;
      if (m_wen) m_busy[m_rd] = 1'b0;
      if (acc && issue_wb && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
      if (g >= 0) begin
        m_wen = (prd[g] != 5'd0); m_rd = prd[g]; m_data = pdata[g];
        m_ptr = (g + 1) % N; pend[g] = 1'b0;
      end else begin
        m_wen = 1'b0;
      end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    foreach (rf[r]) rf[r] = '0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_raw_stall();
    test_x0();
    test_collision();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
